rt_word_loader: RTL and testbench



---
 rtl/rt_word_loader.sv | 91 +++++++++
 tb/tb_rt_word_loader.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rt_word_loader.sv
// Captures the Montgomery r/t operands from the secondary-input stream (MSW first)
// into two LSW-first word buffers and serves them through a registered read port.
module rt_word_loader #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int WORDS      = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_load,
  input  logic [DATA_WIDTH-1:0] n0p_in,
  input  logic                  word_valid,
  input  logic [DATA_WIDTH-1:0] r_word,
  input  logic [DATA_WIDTH-1:0] t_word,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_r,
  output logic [DATA_WIDTH-1:0] rd_t,
  output logic [DATA_WIDTH-1:0] n0p,
  output logic                  busy,
  output logic                  loaded,
  output logic                  overrun
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, READY = 2'd2} state_t;

  state_t                state;
  logic [ADDR_WIDTH:0]   cnt;
  logic [DATA_WIDTH-1:0] r_mem [WORDS];
  logic [DATA_WIDTH-1:0] t_mem [WORDS];
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;

  // A coincident start_load discards the word; the stream restarts from scratch.
  assign wr_en   = !reset && !start_load && (state == LOAD) && word_valid;
  assign wr_addr = ADDR_WIDTH'(WORDS - 1) - cnt[ADDR_WIDTH-1:0];

  // Buffers are not reset so a reset mid-load leaves the partial contents intact.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= r_word;
      t_mem[wr_addr] <= t_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      loaded  <= 1'b0;
      overrun <= 1'b0;
      n0p     <= '0;
      rd_r    <= '0;
      rd_t    <= '0;
    end else begin
      rd_r <= r_mem[rd_addr];
      rd_t <= t_mem[rd_addr];
      if (start_load) begin
        state   <= LOAD;
        cnt     <= '0;
        n0p     <= n0p_in;
        overrun <= 1'b0;
        busy    <= 1'b1;
        loaded  <= 1'b0;
      end else begin
        case (state)
          LOAD: begin
            if (word_valid) begin
              cnt <= cnt + 1'b1;
              if (cnt == (ADDR_WIDTH+1)'(WORDS - 1)) begin
                state  <= READY;
                busy   <= 1'b0;
                loaded <= 1'b1;
              end
            end
          end
          READY: begin
            if (word_valid) overrun <= 1'b1;
            if (clear) begin
              state  <= IDLE;
              loaded <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rt_word_loader.sv
// Randomized self-checking bench for rt_word_loader against a word-queue reference model.
module tb_rt_word_loader;

  logic        clk, reset, start_load, word_valid, clear;
  logic [63:0] n0p_in, r_word, t_word, rd_r, rd_t, n0p;
  logic [5:0]  rd_addr;
  logic        busy, loaded, overrun;

  int checks = 0;
  int errors = 0;

  // Reference: words received in arrival order, then mapped to LSW-first addresses.
  logic [63:0] ref_r [64];
  logic [63:0] ref_t [64];
  logic [63:0] ref_n0p;
  logic [63:0] w_r [64];
  logic [63:0] w_t [64];

  rt_word_loader dut (
    .clk(clk), .reset(reset), .start_load(start_load), .n0p_in(n0p_in),
    .word_valid(word_valid), .r_word(r_word), .t_word(t_word), .clear(clear),
    .rd_addr(rd_addr), .rd_r(rd_r), .rd_t(rd_t), .n0p(n0p),
    .busy(busy), .loaded(loaded), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic read_word(input logic [5:0] a, output logic [63:0] r, output logic [63:0] t);
    rd_addr = a;
    step();
    r = rd_r;
    t = rd_t;
  endtask

  // mode 0: back-to-back, 1: one idle cycle between words, 2: random gaps with random clear
  // rnd: random data instead of rb+i / tb+i. bad counts cycles with busy low or loaded high mid-load.
  task automatic do_load(input logic [63:0] n0, input int mode, input bit rnd,
                         input logic [63:0] rb, input logic [63:0] tbase, output int bad);
    int gaps;
    bad = 0;
    start_load = 1'b1;
    n0p_in = n0;
    step();
    start_load = 1'b0;
    word_valid = 1'b0;
    for (int i = 0; i < 64; i++) begin
      gaps = (mode == 1 && i > 0) ? 1 : (mode == 2) ? int'($urandom_range(0, 3)) : 0;
      repeat (gaps) begin
        word_valid = 1'b0;
        clear = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        step();
        if (!busy || loaded) bad++;
      end
      clear = 1'b0;
      word_valid = 1'b1;
      r_word = rnd ? {$urandom, $urandom} : rb + 64'(i);
      t_word = rnd ? {$urandom, $urandom} : tbase + 64'(i);
      w_r[i] = r_word;
      w_t[i] = t_word;
      step();
      if (i < 63 && (!busy || loaded)) bad++;
    end
    word_valid = 1'b0;
    for (int i = 0; i < 64; i++) begin
      ref_r[63-i] = w_r[i];
      ref_t[63-i] = w_t[i];
    end
    ref_n0p = n0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) step();
    checks++;
    if ({busy, loaded, overrun} !== 3'b000 || n0p !== 64'h0 || rd_r !== 64'h0 || rd_t !== 64'h0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b loaded=%b overrun=%b n0p=%h rd_r=%h rd_t=%h, all required 0",
               busy, loaded, overrun, n0p, rd_r, rd_t);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      word_valid = 1'b1;
      clear = 1'(i);
      r_word = {$urandom, $urandom};
      step();
    end
    word_valid = 1'b0;
    clear = 1'b0;
    step();
    checks++;
    if ({busy, loaded, overrun} !== 3'b000) begin
      errors++;
      $display("FAIL idle_ignore: busy/loaded/overrun=%b required 000", {busy, loaded, overrun});
    end
  endtask

  task automatic check_contents(input string name);
    logic [63:0] r, t;
    int bad = 0;
    for (int a = 0; a < 64; a++) begin
      read_word(6'(a), r, t);
      if (r !== ref_r[a] || t !== ref_t[a]) begin
        bad++;
        if (bad <= 3)
          $display("FAIL %s addr %0d: rd_r=%h rd_t=%h required %h %h", name, a, r, t, ref_r[a], ref_t[a]);
      end
    end
    checks++;
    if (bad != 0) errors++;
  endtask

  task automatic test_back_to_back;
    int bad;
    logic [63:0] r, t;
    do_load(64'hDEAD_BEEF_0000_0001, 0, 1'b0, 64'h0, 64'h100, bad);
    checks++;
    if (bad != 0 || loaded !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_timing: bad_cycles=%0d loaded=%b busy=%b required 0 1 0", bad, loaded, busy);
    end
    checks++;
    if (n0p !== 64'hDEAD_BEEF_0000_0001) begin
      errors++;
      $display("FAIL b2b_n0p: got %h required DEADBEEF00000001", n0p);
    end
    read_word(6'd0, r, t);
    checks++;
    if (r !== 64'd63 || t !== 64'h13F) begin
      errors++;
      $display("FAIL b2b_addr0: rd_r=%h rd_t=%h required 3f 13f", r, t);
    end
    read_word(6'd63, r, t);
    checks++;
    if (r !== 64'd0 || t !== 64'h100) begin
      errors++;
      $display("FAIL b2b_addr63: rd_r=%h rd_t=%h required 0 100", r, t);
    end
    check_contents("b2b_contents");
  endtask

  task automatic test_gap;
    int bad;
    do_load(64'hDEAD_BEEF_0000_0001, 1, 1'b0, 64'h0, 64'h100, bad);
    checks++;
    if (bad != 0 || loaded !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL gap_timing: bad_cycles=%0d loaded=%b busy=%b required 0 1 0", bad, loaded, busy);
    end
    check_contents("gap_contents");
  endtask

  task automatic test_overrun;
    logic [63:0] r, t;
    word_valid = 1'b1;
    r_word = 64'hFFFF;
    t_word = 64'hFFFF;
    step();
    word_valid = 1'b0;
    checks++;
    if (overrun !== 1'b1 || loaded !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: overrun=%b loaded=%b required 1 1", overrun, loaded);
    end
    read_word(6'd0, r, t);
    checks++;
    if (r !== 64'd63) begin
      errors++;
      $display("FAIL overrun_untouched: rd_r=%h required 3f", r);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++;
    if (loaded !== 1'b0 || overrun !== 1'b1 || busy !== 1'b0 || n0p !== ref_n0p) begin
      errors++;
      $display("FAIL clear_ready: loaded=%b overrun=%b busy=%b n0p=%h required 0 1 0 %h",
               loaded, overrun, busy, n0p, ref_n0p);
    end
    check_contents("clear_retained");
    start_load = 1'b1;
    n0p_in = 64'h1234_5678_9ABC_DEF0;
    step();
    start_load = 1'b0;
    checks++;
    if (overrun !== 1'b0 || busy !== 1'b1 || n0p !== 64'h1234_5678_9ABC_DEF0) begin
      errors++;
      $display("FAIL restart_clears_overrun: overrun=%b busy=%b n0p=%h required 0 1 123456789abcdef0",
               overrun, busy, n0p);
    end
  endtask

  task automatic test_restart;
    int bad;
    logic [63:0] r, t;
    start_load = 1'b1;
    n0p_in = 64'h5555;
    step();
    start_load = 1'b0;
    for (int i = 0; i < 10; i++) begin
      word_valid = 1'b1;
      r_word = {$urandom, $urandom};
      t_word = {$urandom, $urandom};
      step();
    end
    // Word coincident with the restart pulse must be dropped.
    r_word = 64'hBAD0;
    t_word = 64'hBAD1;
    do_load(64'hCAFE_0000_0000_0042, 0, 1'b0, 64'hA00, 64'hB00, bad);
    checks++;
    if (bad != 0 || loaded !== 1'b1 || n0p !== 64'hCAFE_0000_0000_0042) begin
      errors++;
      $display("FAIL restart_load: bad_cycles=%0d loaded=%b n0p=%h required 0 1 cafe000000000042",
               bad, loaded, n0p);
    end
    read_word(6'd63, r, t);
    checks++;
    if (r !== 64'hA00 || t !== 64'hB00) begin
      errors++;
      $display("FAIL restart_addr63: rd_r=%h rd_t=%h required a00 b00", r, t);
    end
    check_contents("restart_contents");
  endtask

  task automatic test_random;
    int bad;
    logic [63:0] r, t, n0;
    logic [5:0] a;
    int mis = 0;
    for (int k = 0; k < 3; k++) begin
      n0 = {$urandom, $urandom};
      do_load(n0, 2, 1'b1, 64'h0, 64'h0, bad);
      checks++;
      if (bad != 0 || loaded !== 1'b1 || n0p !== n0) begin
        errors++;
        $display("FAIL random_load%0d: bad_cycles=%0d loaded=%b n0p=%h required 0 1 %h",
                 k, bad, loaded, n0p, n0);
      end
      for (int j = 0; j < 40; j++) begin
        a = 6'($urandom_range(0, 63));
        read_word(a, r, t);
        if (r !== ref_r[a] || t !== ref_t[a]) begin
          mis++;
          if (mis <= 3)
            $display("FAIL random_read addr %0d: rd_r=%h rd_t=%h required %h %h", a, r, t, ref_r[a], ref_t[a]);
        end
      end
      checks++;
      if (mis != 0) errors++;
      mis = 0;
    end
  endtask

  task automatic test_reset_mid;
    start_load = 1'b1;
    n0p_in = 64'h7777;
    step();
    start_load = 1'b0;
    for (int i = 0; i < 30; i++) begin
      word_valid = 1'b1;
      r_word = {$urandom, $urandom};
      t_word = {$urandom, $urandom};
      ref_r[63-i] = r_word;
      ref_t[63-i] = t_word;
      step();
    end
    word_valid = 1'b0;
    reset = 1'b1;
    step();
    checks++;
    if ({busy, loaded, overrun} !== 3'b000 || rd_r !== 64'h0 || n0p !== 64'h0) begin
      errors++;
      $display("FAIL reset_mid: busy/loaded/overrun=%b rd_r=%h n0p=%h required 000 0 0",
               {busy, loaded, overrun}, rd_r, n0p);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      word_valid = 1'b1;
      r_word = {$urandom, $urandom};
      t_word = {$urandom, $urandom};
      step();
    end
    word_valid = 1'b0;
    checks++;
    if ({busy, loaded, overrun} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_idle: busy/loaded/overrun=%b required 000", {busy, loaded, overrun});
    end
    check_contents("reset_mid_partial");
  endtask

  initial begin
    reset = 1'b1; start_load = 1'b0; word_valid = 1'b0; clear = 1'b0;
    n0p_in = '0; r_word = '0; t_word = '0; rd_addr = '0;
    test_reset();
    test_back_to_back();
    test_gap();
    test_overrun();
    test_restart();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
